// File: rtl/i2c_fifo_pkg.sv
// Shared types, default sizes and Gray-code helpers for the I2C FIFO write side.
package i2c_fifo_pkg;

   localparam int DEF_ADDR_SIZE  = 4;
   localparam int DEF_DATA_WIDTH = 8;

   // Round-robin arbiter state: which requester wins when both are valid.
   typedef enum logic {
      PRI0 = 1'b0,
      PRI1 = 1'b1
   } arb_state_t;

   // Helpers work on a 32-bit container; callers zero-extend and truncate.
   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b = g;
      for (int i = 1; i < 32; i++) begin
         b = b ^ (g >> i);
      end
      return b;
   endfunction

endpackage

// File: rtl/i2c_fifo_rr_arbiter2.sv
// Two-requester round-robin grant. Ready is combinational; preference state
// flips to the other requester after each transfer.
module i2c_fifo_rr_arbiter2
   import i2c_fifo_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       valid0,
   input  logic       valid1,
   input  logic       full,
   output logic       ready0,
   output logic       ready1,
   output arb_state_t state
);

   // Grant the only valid requester, or the preferred one on contention.
   always_comb begin
      ready0 = 1'b0;
      ready1 = 1'b0;
      if (!full) begin
         ready0 = valid0 && (!valid1 || state == PRI0);
         ready1 = valid1 && (!valid0 || state == PRI1);
      end
   end

   // Preference moves away from whoever just transferred; holds otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= PRI0;
      end else begin
         case (state)
            PRI0: if (valid0 && ready0) state <= PRI1;
                  else if (valid1 && ready1) state <= PRI0;
            PRI1: if (valid1 && ready1) state <= PRI0;
                  else if (valid0 && ready0) state <= PRI1;
            default: state <= PRI0;
         endcase
      end
   end

endmodule

// File: rtl/i2c_fifo_write_ctrl.sv
// Write-domain controller of the I2C async FIFO: arbitrates two requesters,
// issues one-cycle-delayed memory writes, and keeps Gray pointer and flags.
// Optional macro I2C_FIFO_WRITE_LEVEL_EN adds the registered write_level_o.
module i2c_fifo_write_ctrl
   import i2c_fifo_pkg::*;
#(
   parameter int addr_size       = DEF_ADDR_SIZE,
   parameter int data_width      = DEF_DATA_WIDTH,
   parameter int almost_full_gap = 2
) (
   input  logic                  write_clock_i,
   input  logic                  write_reset_n_i,
   input  logic                  req0_valid_i,
   input  logic [data_width-1:0] req0_data_i,
   output logic                  req0_ready_o,
   input  logic                  req1_valid_i,
   input  logic [data_width-1:0] req1_data_i,
   output logic                  req1_ready_o,
   input  logic [addr_size:0]    read_to_write_pointer_i,
   output logic                  write_enable_o,
   output logic [addr_size-1:0]  write_address_o,
   output logic [data_width-1:0] write_data_o,
   output logic [addr_size:0]    write_pointer_o,
`ifdef I2C_FIFO_WRITE_LEVEL_EN
   output logic [addr_size:0]    write_level_o,
`endif
   output logic                  full_o,
   output logic                  almost_full_o
);

   localparam int PW = addr_size + 1;
   localparam logic [PW-1:0] DEPTH     = PW'(1) << addr_size;
   localparam logic [PW-1:0] GAP       = PW'(almost_full_gap);
   // Full when the write pointer is exactly one lap ahead: top two Gray bits differ.
   localparam logic [PW-1:0] FULL_MASK = {2'b11, {(addr_size-1){1'b0}}};

   arb_state_t          arb_state;
   logic                push;
   logic [PW-1:0]       wbin;
   logic [PW-1:0]       wbin_next;
   logic [PW-1:0]       wgray_next;
   logic [PW-1:0]       rbin;
   logic [PW-1:0]       used_next;
   logic [PW-1:0]       free_next;
   logic [data_width-1:0] push_data;

   i2c_fifo_rr_arbiter2 u_arb (
      .clk    (write_clock_i),
      .rst_n  (write_reset_n_i),
      .valid0 (req0_valid_i),
      .valid1 (req1_valid_i),
      .full   (full_o),
      .ready0 (req0_ready_o),
      .ready1 (req1_ready_o),
      .state  (arb_state)
   );

   // Next pointer and flag terms, evaluated with this cycle's transfer and read pointer.
   always_comb begin
      push       = (req0_valid_i && req0_ready_o) || (req1_valid_i && req1_ready_o);
      push_data  = req0_ready_o ? req0_data_i : req1_data_i;
      wbin_next  = wbin + PW'(push);
      wgray_next = PW'(bin2gray(32'(wbin_next)));
      rbin       = PW'(gray2bin(32'(read_to_write_pointer_i)));
      used_next  = wbin_next - rbin;
      free_next  = DEPTH - used_next;
   end

   // Memory write strobe and payload, one cycle after the transfer edge.
   always_ff @(posedge write_clock_i or negedge write_reset_n_i) begin
      if (!write_reset_n_i) begin
         write_enable_o  <= 1'b0;
         write_address_o <= '0;
         write_data_o    <= '0;
      end else begin
         write_enable_o <= push;
         if (push) begin
            write_address_o <= wbin[addr_size-1:0];
            write_data_o    <= push_data;
         end
      end
   end

   // Pointer and status registers; status also tracks read-pointer motion.
   always_ff @(posedge write_clock_i or negedge write_reset_n_i) begin
      if (!write_reset_n_i) begin
         wbin            <= '0;
         write_pointer_o <= '0;
         full_o          <= 1'b0;
         almost_full_o   <= 1'b0;
      end else begin
         wbin            <= wbin_next;
         write_pointer_o <= wgray_next;
         full_o          <= (wgray_next == (read_to_write_pointer_i ^ FULL_MASK));
         almost_full_o   <= (free_next <= GAP);
      end
   end

`ifdef I2C_FIFO_WRITE_LEVEL_EN
   // Occupancy seen from the write side after this cycle's update.
   always_ff @(posedge write_clock_i or negedge write_reset_n_i) begin
      if (!write_reset_n_i) write_level_o <= '0;
      else                  write_level_o <= used_next;
   end
`endif

endmodule

// File: tb/tb_i2c_fifo_write_ctrl.sv
// Directed + randomized bench for i2c_fifo_write_ctrl against an integer-count model.
module tb_i2c_fifo_write_ctrl;

   localparam int AW = 4, DW = 8, GAP = 2, DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          v0 = 1'b0, v1 = 1'b0;
   logic [DW-1:0] d0 = '0, d1 = '0;
   logic [AW:0]   rptr = '0;
   logic          r0, r1, we, full, af;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic [AW:0]   wptr;
`ifdef I2C_FIFO_WRITE_LEVEL_EN
   logic [AW:0]   level;
`endif

   int checks = 0, errors = 0;

   // Model: total writes/reads as plain counts, and who is preferred next.
   int            wcnt, rcnt;
   bit            pref1;
   logic          exp_we, exp_full, exp_af;
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_data;

   i2c_fifo_write_ctrl #(.addr_size(AW), .data_width(DW), .almost_full_gap(GAP)) dut (
      .write_clock_i           (clk),
      .write_reset_n_i         (rst_n),
      .req0_valid_i            (v0),
      .req0_data_i             (d0),
      .req0_ready_o            (r0),
      .req1_valid_i            (v1),
      .req1_data_i             (d1),
      .req1_ready_o            (r1),
      .read_to_write_pointer_i (rptr),
      .write_enable_o          (we),
      .write_address_o         (waddr),
      .write_data_o            (wdata),
      .write_pointer_o         (wptr),
`ifdef I2C_FIFO_WRITE_LEVEL_EN
      .write_level_o           (level),
`endif
      .full_o                  (full),
      .almost_full_o           (af)
   );

   always #5 clk = ~clk;

   function automatic logic [AW:0] gray(input int n);
      logic [AW:0] b;
      b = n[AW:0];
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      wcnt = 0; rcnt = 0; pref1 = 1'b0;
      exp_we = 1'b0; exp_addr = '0; exp_data = '0; exp_full = 1'b0; exp_af = 1'b0;
   endtask

   task automatic check_regs(input string tag);
      chk({tag, ".we"},    32'(we),    32'(exp_we));
      chk({tag, ".addr"},  32'(waddr), 32'(exp_addr));
      chk({tag, ".data"},  32'(wdata), 32'(exp_data));
      chk({tag, ".wptr"},  32'(wptr),  32'(gray(wcnt)));
      chk({tag, ".full"},  32'(full),  32'(exp_full));
      chk({tag, ".afull"}, 32'(af),    32'(exp_af));
`ifdef I2C_FIFO_WRITE_LEVEL_EN
      chk({tag, ".level"}, 32'(level), 32'(wcnt - rcnt));
`endif
   endtask

   // Reset asserted mid-cycle: outputs must clear at once, without a clock.
   task automatic do_reset();
      rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; rptr = '0;
      model_reset();
      #1;
      check_regs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // One clock: apply inputs, check ready, advance the model, check registers.
   task automatic cycle(input string tag, input bit a0, input logic [DW-1:0] x0,
                        input bit a1, input logic [DW-1:0] x1, input bit radv);
      bit er0, er1;
      int used;
      v0 = a0; d0 = x0; v1 = a1; d1 = x1;
      if (radv && rcnt < wcnt) rcnt++;
      rptr = gray(rcnt);
      #1;
      er0 = !exp_full && a0 && (!a1 || !pref1);
      er1 = !exp_full && a1 && (!a0 || pref1);
      chk({tag, ".ready0"}, 32'(r0), 32'(er0));
      chk({tag, ".ready1"}, 32'(r1), 32'(er1));
      exp_we = er0 || er1;
      if (exp_we) begin
         exp_addr = AW'(wcnt % DEPTH);
         exp_data = er0 ? x0 : x1;
         wcnt++;
         pref1 = er0;
      end
      used     = wcnt - rcnt;
      exp_full = (used == DEPTH);
      exp_af   = ((DEPTH - used) <= GAP);
      @(posedge clk); #1;
      check_regs(tag);
   endtask

   initial begin
      do_reset();

      // Single requester 0 write of 0x5A.
      cycle("first", 1'b1, 8'h5A, 1'b0, 8'h00, 1'b0);
      chk("first.wptr_lit", 32'(wptr), 32'h1);
      cycle("idle", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

      // Contention with a stalled reader: alternating grants until full.
      do_reset();
      for (int i = 0; i < 16; i++) begin
         cycle("fill", 1'b1, 8'($urandom), 1'b1, 8'($urandom), 1'b0);
         if (i == 13) chk("fill.af_at14", 32'(af), 32'h1);
         if (i == 12) chk("fill.af_at13", 32'(af), 32'h0);
      end
      chk("fill.full16", 32'(full), 32'h1);
      cycle("stall", 1'b1, 8'h11, 1'b1, 8'h22, 1'b0);

      // Reader frees one entry: full drops with no transfer, then refills.
      cycle("radv", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      chk("radv.full_clear", 32'(full), 32'h0);
      cycle("refill", 1'b1, 8'h33, 1'b1, 8'h44, 1'b0);
      chk("refill.full", 32'(full), 32'h1);
      cycle("stall2", 1'b1, 8'h55, 1'b0, 8'h00, 1'b0);

      // Last free entry written in the same cycle the reader advances.
      cycle("radv2", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      cycle("simul", 1'b1, 8'h66, 1'b0, 8'h00, 1'b1);
      chk("simul.full", 32'(full), 32'h0);

      // Wrap-around with the reader keeping up.
      do_reset();
      for (int n = 0; n < 300 && wcnt < 40; n++) begin
         cycle("wrap", 1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 1'b1);
      end
      chk("wrap.count", 32'(wcnt), 32'd40);

      // Random traffic, random reader progress, valids dropping freely.
      for (int n = 0; n < 300; n++) begin
         cycle("rand", 1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom),
               ($urandom_range(0, 2) == 0));
      end

      // Reset lands during the write cycle of a transfer.
      cycle("pre_rst", 1'b1, 8'hC3, 1'b0, 8'h00, 1'b0);
      do_reset();
      cycle("post_rst", 1'b0, 8'h00, 1'b1, 8'h7E, 1'b0);
      chk("post_rst.addr0", 32'(waddr), 32'h0);

      // Five writes, two reads: occupancy of three.
      do_reset();
      for (int i = 0; i < 5; i++) cycle("lvl", 1'b1, 8'(i), 1'b0, 8'h00, (i >= 3));
      chk("lvl.used", 32'(wcnt - rcnt), 32'd3);
`ifdef I2C_FIFO_WRITE_LEVEL_EN
      chk("lvl.level3", 32'(level), 32'd3);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
